mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWaitR = 2'd2,
    StDone  = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data-bus signals of mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              access_fault;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport slave (
    input  req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output busy, done, rdata, access_fault,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  busy, done, rdata, access_fault,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [1:0]  st_addr_lo_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // Misaligned halves/words are forced to natural alignment here.
  always_comb begin
    st_addr_lo_o = st_addr_lo_i;
    st_be_o      = 4'b0000;
    st_wdata_o   = st_wdata_i;
    case (mem_size_e'(st_size_i))
      MEM_B: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      MEM_H: begin
        st_addr_lo_o = {st_addr_lo_i[1], 1'b0};
        st_be_o      = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o   = {2{st_wdata_i[15:0]}};
      end
      MEM_W: begin
        st_addr_lo_o = 2'b00;
        st_be_o      = 4'b1111;
      end
      default: st_be_o = 4'b0000;
    endcase
  end

  assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (mem_size_e'(ld_size_i))
      MEM_B: ld_data_o = {{24{~ld_unsigned_i & ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_H: ld_data_o = {{16{~ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: captures one decoded access, runs it on the data bus, returns load data.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  mau
);

  mau_state_e        st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]  st_addr_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        misalign_fault;
  logic        fault;
  logic        access;
  logic        accept;

  mem_lane_align u_lane_align (
    .st_size_i     (mau.mem_size),
    .st_addr_lo_i  (mau.addr[1:0]),
    .st_wdata_i    (mau.wdata),
    .st_addr_lo_o  (st_addr_lo),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_q[1:0]),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (mau.bus_rdata),
    .ld_data_o     (ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  assign misalign_fault = ((mau.mem_size == MEM_H) && mau.addr[0]) ||
                          ((mau.mem_size == MEM_W) && (mau.addr[1:0] != 2'b00));
`else
  assign misalign_fault = 1'b0;
`endif

  assign access = (st_q == StIdle) && mau.req_valid && (mau.mem_read || mau.mem_write);
  assign fault  = (mau.mem_size == 2'b11) || (mau.mem_read && mau.mem_write) || misalign_fault;
  assign accept = access && !fault;

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (st_q)
      StIdle: begin
        if (accept) begin
          st_d    = StReq;
          addr_d  = {mau.addr[ADDR_W-1:2], st_addr_lo};
          size_d  = mau.mem_size;
          uns_d   = mau.mem_unsigned;
          we_d    = mau.mem_write;
          be_d    = st_be;
          wdata_d = st_wdata;
        end
      end
      StReq: begin
        if (mau.bus_gnt) st_d = we_q ? StDone : StWaitR;
      end
      StWaitR: begin
        // Read data in the grant cycle never reaches here, so it is ignored.
        if (mau.bus_rvalid) begin
          rdata_d = ld_data;
          st_d    = StDone;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Combinational outputs are gated so they read 0 while reset is held.
  assign mau.busy         = rst_n && (accept || (st_q == StReq) || (st_q == StWaitR));
  assign mau.access_fault = rst_n && access && fault;
  assign mau.done         = (st_q == StDone);
  assign mau.rdata        = rdata_q;
  assign mau.bus_req      = (st_q == StReq);
  assign mau.bus_we       = (st_q == StReq) && we_q;
  assign mau.bus_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign mau.bus_be       = be_q;
  assign mau.bus_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a behavioural load/store model.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] last_rdata;

  mem_access_unit_if #(.ADDR_W(32)) mau_if ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mau   (mau_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte offset actually used after natural alignment.
  function automatic int eff_off(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return int'(a % 4);
    if (size == 2'd1) return int'(a & 32'd2);
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    int off = eff_off(size, a);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] b = w & 32'hFF;
    logic [31:0] h = w & 32'hFFFF;
    if (size == 2'd0) return b * 32'h0101_0101;
    if (size == 2'd1) return h * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] a, input logic [31:0] bus);
    logic [31:0] v = bus >> (8 * eff_off(size, a));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit model_fault(input bit rd, input bit wr, input logic [1:0] size,
                                     input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (size == 2'd3 || (rd && wr)) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1 && (a % 2) != 0) return 1'b1;
    if (size == 2'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic scramble_inputs();
    mau_if.mem_read     = 1'($urandom);
    mau_if.mem_write    = 1'($urandom);
    mau_if.mem_size     = 2'($urandom);
    mau_if.mem_unsigned = 1'($urandom);
    mau_if.addr         = $urandom;
    mau_if.wdata        = $urandom;
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rbus,
                           input int gnt_dly, input int rv_dly);
    bit          flt;
    bit          act;
    bit          granted;
    bit          done_seen;
    int          cyc;
    int          wcnt;
    int          rcnt;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    flt      = model_fault(rd, wr, size, a);
    act      = (rd || wr) && !flt;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = model_be(size, a);
    exp_wd   = model_wdata(size, wd);
    exp_lat  = wr ? gnt_dly + 2 : gnt_dly + rv_dly + 3;

    @(negedge clk);
    mau_if.req_valid    = 1'b1;
    mau_if.mem_read     = rd;
    mau_if.mem_write    = wr;
    mau_if.mem_size     = size;
    mau_if.mem_unsigned = uns;
    mau_if.addr         = a;
    mau_if.wdata        = wd;
    #1;
    check_eq("busy_present", 32'(mau_if.busy), 32'(act));
    check_eq("fault_present", 32'(mau_if.access_fault), 32'(flt));
    check_eq("req_in_idle", 32'(mau_if.bus_req), 32'd0);
    @(posedge clk);
    #1;
    mau_if.req_valid = 1'b0;
    scramble_inputs();

    if (!act) begin
      @(negedge clk);
      check_eq("noacc_req", 32'(mau_if.bus_req), 32'd0);
      check_eq("noacc_busy", 32'(mau_if.busy), 32'd0);
      check_eq("noacc_fault", 32'(mau_if.access_fault), 32'd0);
      check_eq("noacc_done", 32'(mau_if.done), 32'd0);
      check_eq("noacc_rdata", mau_if.rdata, last_rdata);
      return;
    end

    cyc = 0; wcnt = 0; rcnt = 0; granted = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mau_if.bus_gnt    = 1'b0;
      mau_if.bus_rvalid = 1'b0;
      mau_if.bus_rdata  = $urandom;
      if (mau_if.done) begin
        done_seen = 1'b1;
      end else if (!granted) begin
        check_eq("req_high", 32'(mau_if.bus_req), 32'd1);
        check_eq("req_addr", mau_if.bus_addr, exp_addr);
        check_eq("req_be", 32'(mau_if.bus_be), 32'(exp_be));
        check_eq("req_we", 32'(mau_if.bus_we), 32'(wr));
        if (wr) check_eq("req_wdata", mau_if.bus_wdata, exp_wd);
        check_eq("req_busy", 32'(mau_if.busy), 32'd1);
        if (wcnt == gnt_dly) begin
          granted        = 1'b1;
          mau_if.bus_gnt = 1'b1;
          if (rd) begin
            // Read data coinciding with grant must be ignored.
            mau_if.bus_rvalid = 1'b1;
            mau_if.bus_rdata  = ~rbus;
          end
        end
        wcnt++;
      end else begin
        check_eq("wait_req", 32'(mau_if.bus_req), 32'd0);
        check_eq("wait_busy", 32'(mau_if.busy), 32'd1);
        if (rcnt == rv_dly) begin
          mau_if.bus_rvalid = 1'b1;
          mau_if.bus_rdata  = rbus;
        end
        rcnt++;
      end
    end
    mau_if.bus_gnt    = 1'b0;
    mau_if.bus_rvalid = 1'b0;
    check_eq("done_seen", 32'(done_seen), 32'd1);
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("done_busy", 32'(mau_if.busy), 32'd0);
    check_eq("done_req", 32'(mau_if.bus_req), 32'd0);
    if (rd) last_rdata = model_load(size, uns, a, rbus);
    check_eq("rdata", mau_if.rdata, last_rdata);

    // A request presented during DONE must not be taken.
    mau_if.req_valid = 1'b1;
    mau_if.mem_read  = 1'b1;
    mau_if.mem_write = 1'b0;
    mau_if.mem_size  = 2'd2;
    mau_if.addr      = 32'h0000_0400;
    #1;
    check_eq("done_ignore_busy", 32'(mau_if.busy), 32'd0);
    @(posedge clk);
    #1;
    mau_if.req_valid = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", 32'(mau_if.done), 32'd0);
    check_eq("after_done_req", 32'(mau_if.bus_req), 32'd0);
    check_eq("after_done_busy", 32'(mau_if.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(mau_if.bus_req), 32'd0);
    check_eq({tag, "_we"}, 32'(mau_if.bus_we), 32'd0);
    check_eq({tag, "_addr"}, mau_if.bus_addr, 32'd0);
    check_eq({tag, "_be"}, 32'(mau_if.bus_be), 32'd0);
    check_eq({tag, "_wdata"}, mau_if.bus_wdata, 32'd0);
    check_eq({tag, "_done"}, 32'(mau_if.done), 32'd0);
    check_eq({tag, "_rdata"}, mau_if.rdata, 32'd0);
    check_eq({tag, "_fault"}, 32'(mau_if.access_fault), 32'd0);
    check_eq({tag, "_busy"}, 32'(mau_if.busy), 32'd0);
  endtask

  task automatic reset_mid(input bit in_wait);
    @(negedge clk);
    mau_if.req_valid = 1'b1;
    mau_if.mem_read  = 1'b1;
    mau_if.mem_write = 1'b0;
    mau_if.mem_size  = 2'd2;
    mau_if.addr      = 32'h0000_0100;
    @(posedge clk);
    #1;
    mau_if.req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_in_req", 32'(mau_if.bus_req), 32'd1);
    if (in_wait) begin
      mau_if.bus_gnt = 1'b1;
      @(negedge clk);
      mau_if.bus_gnt = 1'b0;
      check_eq("abort_wait_req", 32'(mau_if.bus_req), 32'd0);
      check_eq("abort_wait_busy", 32'(mau_if.busy), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(in_wait ? "rst_wait" : "rst_req");
    last_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mau_if.bus_rvalid = (i == 0);
      check_eq("abort_no_done", 32'(mau_if.done), 32'd0);
      check_eq("abort_no_req", 32'(mau_if.bus_req), 32'd0);
    end
    mau_if.bus_rvalid = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    last_rdata        = 32'h0;
    rst_n             = 1'b0;
    mau_if.req_valid  = 1'b1;
    mau_if.mem_read   = 1'b1;
    mau_if.mem_write  = 1'b0;
    mau_if.mem_size   = 2'd2;
    mau_if.mem_unsigned = 1'b0;
    mau_if.addr       = 32'h0000_0200;
    mau_if.wdata      = 32'h0;
    mau_if.bus_gnt    = 1'b0;
    mau_if.bus_rvalid = 1'b0;
    mau_if.bus_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    mau_if.req_valid = 1'b0;
    rst_n = 1'b1;

    // sw 0xDEADBEEF to 0x104, immediate grant.
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check_eq("sw_addr", mau_if.bus_addr, 32'h0000_0104);
    check_eq("sw_be", 32'(mau_if.bus_be), 32'hF);
    check_eq("sw_wdata", mau_if.bus_wdata, 32'hDEAD_BEEF);
    // lb / lbu from 0x203.
    do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0, 0);
    check_eq("lb_be", 32'(mau_if.bus_be), 32'h8);
    check_eq("lb_rdata", mau_if.rdata, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1, 2);
    check_eq("lbu_rdata", mau_if.rdata, 32'h0000_0080);
    // sh 0x1234 to 0x302 with grant delayed 3 cycles.
    do_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h0000_1234, 32'h0, 3, 0);
    check_eq("sh_be", 32'(mau_if.bus_be), 32'hC);
    check_eq("sh_wdata", mau_if.bus_wdata, 32'h1234_1234);
    check_eq("sh_keeps_rdata", mau_if.rdata, 32'h0000_0080);
    // lw from misaligned 0x101.
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifndef MISALIGN_TRAP_EN
    check_eq("lw_mis_addr", mau_if.bus_addr, 32'h0000_0100);
    check_eq("lw_mis_be", 32'(mau_if.bus_be), 32'hF);
    check_eq("lw_mis_rdata", mau_if.rdata, 32'hCAFE_F00D);
`endif
    // Illegal encodings.
    do_access(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 0, 0);
    do_access(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 0, 0);
    // Reset during REQ and WAIT_R, then a normal lw.
    reset_mid(1'b0);
    reset_mid(1'b1);
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 2, 1);
    check_eq("post_reset_lw", mau_if.rdata, 32'h1357_9BDF);

    for (int i = 0; i < 300; i++) begin
      int  op;
      bit  rd;
      bit  wr;
      logic [1:0] sz;
      op = int'($urandom_range(0, 9));
      rd = (op < 4) || (op == 8);
      wr = (op >= 4 && op < 8) || (op == 8);
      if (op == 9) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_access(rd, wr, sz, 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
